regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file for the single-cycle MIPS datapath and its planned successors. It has two combinational read ports, a debug read port, and two synchronous write ports with fixed priority. It optionally hardwires register 0 to zero and optionally bypasses same-cycle writes to the read ports. A post-reset clear sequencer zeroes every entry, one per cycle, and reports this through a busy flag.

Parameters:
DATA_W, 32, width of each register in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes
BYPASS, 1, 1 = read ports return same-cycle write data on address match

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
reg1_in  in  ADDR_W  read port 1 address
reg2_in  in  ADDR_W  read port 2 address
reg1_out  out  DATA_W  read port 1 data (combinational)
reg2_out  out  DATA_W  read port 2 data (combinational)
dbg_sel  in  ADDR_W  debug read address
dbg_out  out  DATA_W  debug read data (combinational, never bypassed)
we0  in  1  write enable, port 0
rw0  in  ADDR_W  write address, port 0
write_data0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (priority port)
rw1  in  ADDR_W  write address, port 1
write_data1  in  DATA_W  write data, port 1
busy  out  1  1 while the clear sequence runs; writes are ignored
wr_conflict  out  1  registered pulse: both ports wrote the same address last cycle

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; there is no asynchronous path.
- FSM states: CLEAR and READY.
  - Rising edge with rst=1: state<=CLEAR, clr_ptr<=0, busy<=1, wr_conflict<=0. The array is not modified on that edge.
  - In CLEAR with rst=0: each edge writes 0 to entry clr_ptr, then clr_ptr<=clr_ptr+1.
  - When clr_ptr==DEPTH-1, the sweep writes that entry, then state<=READY and busy<=0.
  - After rst deasserts, the sweep takes exactly DEPTH edges; busy falls on the edge of the final clear write.
  - Holding rst high keeps clr_ptr at 0. Asserting rst mid-sweep or in READY restarts the sweep from 0.
  - Power-up initial state is CLEAR with clr_ptr=0, matching post-reset behaviour for simulation.
- Reset/idle output values:
  - busy=1 and wr_conflict=0.
  - reg1_out, reg2_out and dbg_out are forced to 0 while busy=1.
- Writes in CLEAR state: we0 and we1 are ignored and wr_conflict is not raised.
- Writes in READY state, on each edge:
  - we0=1 writes write_data0 to rw0; we1=1 writes write_data1 to rw1.
  - If both are enabled and rw0==rw1, port 1 wins.
  - If ZERO_REG=1 and the address is 0, the write is dropped.
- wr_conflict is registered and is 1 for exactly the cycle after an edge where all of these held: READY, we0=1, we1=1, rw0==rw1, and the address is not the hardwired zero (when ZERO_REG=1).
- Reads, with BYPASS=0:
  - regN_out = array[regN_in].
  - If ZERO_REG=1 and the address is 0, the output is 0.
- Reads, with BYPASS=1 (state READY):
  - If we1=1 and rw1==regN_in, the output is write_data1.
  - Else if we0=1 and rw0==regN_in, the output is write_data0.
  - Else the output is the array value.
  - The zero rule overrides bypass.
  - The bypass path is combinational from the write inputs; no extra latency.
- dbg_out = array[dbg_sel] with the zero rule applied; it never bypasses.
- Width: data is stored and returned unmodified; there is no sign or zero extension.

Test Plan:
1. Reset then sweep:
   - Stimulus: rst=1 for 2 cycles, then release.
   - Required: busy=1 for exactly 32 edges after release, then 0. All 32 entries read 0 on dbg_out.
   - Required: we0=1, rw0=5, write_data0=0xDEADBEEF during busy leaves entry 5 = 0.
2. Basic write/read:
   - Stimulus (READY): we0=1, rw0=4, write_data0=0x00000007.
   - Required: next cycle, reg1_in=4 gives reg1_out=0x7 and dbg_sel=4 gives dbg_out=0x7.
   - Stimulus: we1=1, rw1=0, write_data1=0xFFFFFFFF.
   - Required: entry 0 still reads 0.
3. Port conflict:
   - Stimulus: we0=we1=1, rw0=rw1=9, write_data0=0x11, write_data1=0x22.
   - Required: entry 9 = 0x22; wr_conflict=1 for one cycle only.
   - Stimulus: repeat with address 0.
   - Required: wr_conflict stays 0.
4. Bypass:
   - Stimulus (BYPASS=1): entry 3 holds 0x5; drive we0=1, rw0=3, write_data0=0xA with reg2_in=3.
   - Required: reg2_out=0xA in the same cycle, while dbg_out (dbg_sel=3) = 0x5.
   - Stimulus: rebuild with BYPASS=0.
   - Required: reg2_out=0x5 in that cycle and 0xA after the edge.
5. Reset mid-sweep:
   - Stimulus: assert rst for 1 cycle at sweep cycle 10.
   - Required: busy stays 1 for a further 32 edges after release.
6. Parametrised build:
   - Stimulus: DATA_W=16, ADDR_W=3, ZERO_REG=0.
   - Required: sweep takes 8 edges; a write of 0xBEEF to entry 0 reads back 0xBEEF.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file for the MIPS datapath.
// Two combinational read ports (optionally bypassing same-cycle writes), a
// debug read port that never bypasses, and two synchronous write ports where
// port 1 wins on an address collision. After reset a sequencer zeroes one
// entry per cycle and holds busy high until the sweep completes.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reg1_in/reg1_out          read port 1 address / data (combinational)
//   reg2_in/reg2_out          read port 2 address / data (combinational)
//   dbg_sel/dbg_out           debug read address / data (no bypass)
//   we0, rw0, write_data0     write port 0
//   we1, rw1, write_data1     write port 1 (priority)
//   busy                      high while the clear sweep runs
//   wr_conflict               one-cycle pulse after a same-address dual write
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] reg1_in,
  input  logic [ADDR_W-1:0] reg2_in,
  output logic [DATA_W-1:0] reg1_out,
  output logic [DATA_W-1:0] reg2_out,
  input  logic [ADDR_W-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_out,
  input  logic              we0,
  input  logic [ADDR_W-1:0] rw0,
  input  logic [DATA_W-1:0] write_data0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] rw1,
  input  logic [DATA_W-1:0] write_data1,
  output logic              busy,
  output logic              wr_conflict
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam int unsigned NUM_RD   = 3;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Declaration values give the post-reset state at power-up in simulation.
  state_t            state_q    = ST_CLEAR;
  state_t            state_d;
  logic [ADDR_W-1:0] clr_ptr_q  = '0;
  logic [ADDR_W-1:0] clr_ptr_d;
  logic              busy_q     = 1'b1;
  logic              busy_d;
  logic              conflict_q = 1'b0;
  logic              conflict_d;

  logic              clr_en;
  logic              wr0_en;
  logic              wr1_en;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] rd_addr [NUM_RD];
  logic [DATA_W-1:0] rd_data [NUM_RD];

  // True when the address refers to the hardwired zero entry.
  function automatic logic is_zero_addr(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // State register plus registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_ptr_q  <= '0;
      busy_q     <= 1'b1;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  // Next-state: walk the clear pointer, leave CLEAR after the last entry.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == ST_CLEAR) begin
      clr_ptr_d = clr_ptr_q + ADDR_W'(1);
      if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
        state_d   = ST_READY;
        clr_ptr_d = '0;
      end
    end
    busy_d = (state_d == ST_CLEAR);
  end

  // Output decode: array write strobes and the conflict flag.
  always_comb begin
    clr_en     = 1'b0;
    wr0_en     = 1'b0;
    wr1_en     = 1'b0;
    conflict_d = 1'b0;
    if (state_q == ST_CLEAR) begin
      clr_en = 1'b1;
    end else begin
      wr0_en     = we0 && !is_zero_addr(rw0);
      wr1_en     = we1 && !is_zero_addr(rw1);
      conflict_d = we0 && we1 && (rw0 == rw1) && !is_zero_addr(rw0);
    end
  end

  // Storage array; port 1 is written last so it wins a collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_en) begin
        mem[clr_ptr_q] <= '0;
      end
      if (wr0_en) begin
        mem[rw0] <= write_data0;
      end
      if (wr1_en) begin
        mem[rw1] <= write_data1;
      end
    end
  end

  assign rd_addr[0] = reg1_in;
  assign rd_addr[1] = reg2_in;
  assign rd_addr[2] = dbg_sel;

  // Read ports 0/1 may bypass; port 2 (debug) always shows the array.
  for (genvar p = 0; p < NUM_RD; p++) begin : gen_rd
    localparam bit BYP_EN = (BYPASS != 0) && (p < 2);
    logic [DATA_W-1:0] data;

    always_comb begin
      data = mem[rd_addr[p]];
      if (BYP_EN && !busy_q) begin
        if (we1 && (rw1 == rd_addr[p])) begin
          data = write_data1;
        end else if (we0 && (rw0 == rd_addr[p])) begin
          data = write_data0;
        end
      end
      // Zero entry and the clear sweep override everything, bypass included.
      if (busy_q || is_zero_addr(rd_addr[p])) begin
        data = '0;
      end
    end

    assign rd_data[p] = data;
  end

  assign reg1_out    = rd_data[0];
  assign reg2_out    = rd_data[1];
  assign dbg_out     = rd_data[2];
  assign busy        = busy_q;
  assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two builds (default, and 16-bit/8-entry with no zero
// register and no bypass) share one stimulus stream. A driver pushes expected
// outputs from a behavioural model; a monitor pops and compares on negedge.
module tb_regfile_mp;

  typedef struct packed {
    logic        rst;
    logic        we0;
    logic        we1;
    logic [4:0]  rw0;
    logic [4:0]  rw1;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  dbg;
    logic [31:0] wd0;
    logic [31:0] wd1;
  } stim_t;

  typedef struct packed {
    logic        busy;
    logic        conf;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] dbg;
  } exp_t;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic        rst;
  logic [4:0]  a_r1, a_r2, a_dbg, a_rw0, a_rw1;
  logic [31:0] a_wd0, a_wd1, a_o1, a_o2, a_od;
  logic        a_we0, a_we1, a_busy, a_conf;
  logic [2:0]  b_r1, b_r2, b_dbg, b_rw0, b_rw1;
  logic [15:0] b_wd0, b_wd1, b_o1, b_o2, b_od;
  logic        b_we0, b_we1, b_busy, b_conf;

  regfile_mp dut_a (
    .clk(clk), .rst(rst),
    .reg1_in(a_r1), .reg2_in(a_r2), .reg1_out(a_o1), .reg2_out(a_o2),
    .dbg_sel(a_dbg), .dbg_out(a_od),
    .we0(a_we0), .rw0(a_rw0), .write_data0(a_wd0),
    .we1(a_we1), .rw1(a_rw1), .write_data1(a_wd1),
    .busy(a_busy), .wr_conflict(a_conf)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst),
    .reg1_in(b_r1), .reg2_in(b_r2), .reg1_out(b_o1), .reg2_out(b_o2),
    .dbg_sel(b_dbg), .dbg_out(b_od),
    .we0(b_we0), .rw0(b_rw0), .write_data0(b_wd0),
    .we1(b_we1), .rw1(b_rw1), .write_data1(b_wd1),
    .busy(b_busy), .wr_conflict(b_conf)
  );

  int checks = 0;
  int errors = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // Reference model: per build, an array, cycles left in the sweep, and the
  // conflict flag produced by the previous edge.
  logic [31:0] mdl_mem [2][32];
  int          mdl_left [2] = '{32, 8};
  logic        mdl_conf [2] = '{1'b0, 1'b0};
  stim_t       cur;

  function automatic int depth_of(input int c);
    return (c == 0) ? 32 : 8;
  endfunction
  function automatic logic [4:0] amask(input int c);
    return (c == 0) ? 5'h1F : 5'h07;
  endfunction
  function automatic logic [31:0] dmask(input int c);
    return (c == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction
  function automatic bit has_zero(input int c);
    return c == 0;
  endfunction
  function automatic bit has_byp(input int c);
    return c == 0;
  endfunction

  task automatic model_edge(input stim_t s);
    for (int c = 0; c < 2; c++) begin
      logic [4:0] a0, a1;
      bit ready;
      a0 = s.rw0 & amask(c);
      a1 = s.rw1 & amask(c);
      ready = (mdl_left[c] == 0);
      if (s.rst) begin
        mdl_left[c] = depth_of(c);
        mdl_conf[c] = 1'b0;
      end else if (ready) begin
        mdl_conf[c] = s.we0 && s.we1 && (a0 == a1) && !(has_zero(c) && a0 == 0);
        if (s.we0 && !(has_zero(c) && a0 == 0)) mdl_mem[c][a0] = s.wd0 & dmask(c);
        if (s.we1 && !(has_zero(c) && a1 == 0)) mdl_mem[c][a1] = s.wd1 & dmask(c);
      end else begin
        mdl_conf[c] = 1'b0;
        mdl_left[c] = mdl_left[c] - 1;
        if (mdl_left[c] == 0) begin
          for (int i = 0; i < 32; i++) mdl_mem[c][i] = 32'h0;
        end
      end
    end
  endtask

  function automatic logic [31:0] mdl_read(input int c, input logic [4:0] addr,
                                           input stim_t s, input bit allow_byp);
    logic [4:0] a;
    a = addr & amask(c);
    if (has_zero(c) && a == 0) return 32'h0;
    if (allow_byp && has_byp(c)) begin
      if (s.we1 && (s.rw1 & amask(c)) == a) return s.wd1 & dmask(c);
      if (s.we0 && (s.rw0 & amask(c)) == a) return s.wd0 & dmask(c);
    end
    return mdl_mem[c][a];
  endfunction

  function automatic exp_t mdl_expect(input int c, input stim_t s);
    exp_t e;
    e.busy = (mdl_left[c] > 0);
    e.conf = mdl_conf[c];
    e.r1   = 32'h0;
    e.r2   = 32'h0;
    e.dbg  = 32'h0;
    if (!e.busy) begin
      e.r1  = mdl_read(c, s.r1, s, 1'b1);
      e.r2  = mdl_read(c, s.r2, s, 1'b1);
      e.dbg = mdl_read(c, s.dbg, s, 1'b0);
    end
    return e;
  endfunction

  task automatic apply(input stim_t s);
    cur   = s;
    rst   = s.rst;
    a_we0 = s.we0;  a_we1 = s.we1;
    a_rw0 = s.rw0;  a_rw1 = s.rw1;
    a_wd0 = s.wd0;  a_wd1 = s.wd1;
    a_r1  = s.r1;   a_r2  = s.r2;   a_dbg = s.dbg;
    b_we0 = s.we0;  b_we1 = s.we1;
    b_rw0 = s.rw0[2:0];  b_rw1 = s.rw1[2:0];
    b_wd0 = s.wd0[15:0]; b_wd1 = s.wd1[15:0];
    b_r1  = s.r1[2:0];   b_r2  = s.r2[2:0];   b_dbg = s.dbg[2:0];
  endtask

  // Advance one edge: fold the applied inputs into the model, then drive the
  // next inputs and queue what the DUTs must show before the following edge.
  task automatic cycle(input stim_t s);
    @(posedge clk);
    #1;
    model_edge(cur);
    apply(s);
    q_a.push_back(mdl_expect(0, s));
    q_b.push_back(mdl_expect(1, s));
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s      = '0;
    s.rst  = ($urandom_range(0, 149) == 0);
    s.we0  = 1'($urandom_range(0, 1));
    s.we1  = 1'($urandom_range(0, 1));
    s.rw0  = 5'($urandom_range(0, 31));
    s.rw1  = ($urandom_range(0, 3) == 0) ? s.rw0 : 5'($urandom_range(0, 31));
    s.r1   = ($urandom_range(0, 2) == 0) ? s.rw0 : 5'($urandom_range(0, 31));
    s.r2   = ($urandom_range(0, 2) == 0) ? s.rw1 : 5'($urandom_range(0, 31));
    s.dbg  = 5'($urandom_range(0, 31));
    s.wd0  = $urandom;
    s.wd1  = $urandom;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs against the queued expectations each cycle.
  initial forever begin
    @(negedge clk);
    if (q_a.size() > 0) begin
      exp_t e;
      e = q_a.pop_front();
      check("a_busy", 32'(a_busy), 32'(e.busy));
      check("a_conflict", 32'(a_conf), 32'(e.conf));
      check("a_reg1", a_o1, e.r1);
      check("a_reg2", a_o2, e.r2);
      check("a_dbg", a_od, e.dbg);
    end
    if (q_b.size() > 0) begin
      exp_t e;
      e = q_b.pop_front();
      check("b_busy", 32'(b_busy), 32'(e.busy));
      check("b_conflict", 32'(b_conf), 32'(e.conf));
      check("b_reg1", {16'h0, b_o1}, e.r1);
      check("b_reg2", {16'h0, b_o2}, e.r2);
      check("b_dbg", {16'h0, b_od}, e.dbg);
    end
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    apply(s);
    cycle(s);

    // Sweep after release, with a write hammering entry 5 while busy.
    for (int i = 0; i < 32; i++) begin
      s = idle();
      s.we0 = 1'b1; s.rw0 = 5'd5; s.wd0 = 32'hDEAD_BEEF;
      s.r1 = 5'd5;  s.dbg = 5'd5;
      cycle(s);
    end
    for (int i = 0; i < 32; i++) begin
      s = idle();
      s.dbg = 5'(i); s.r1 = 5'(i); s.r2 = 5'(31 - i);
      cycle(s);
    end

    // Basic write/read and a write to the zero entry.
    s = idle(); s.we0 = 1'b1; s.rw0 = 5'd4; s.wd0 = 32'h7; cycle(s);
    s = idle(); s.r1 = 5'd4; s.dbg = 5'd4; cycle(s);
    s = idle(); s.we1 = 1'b1; s.rw1 = 5'd0; s.wd1 = 32'hFFFF_FFFF; cycle(s);
    s = idle(); s.r1 = 5'd0; s.r2 = 5'd4; s.dbg = 5'd0; cycle(s);

    // Same-address dual writes: to 9, then to the zero entry.
    s = idle(); s.we0 = 1'b1; s.we1 = 1'b1; s.rw0 = 5'd9; s.rw1 = 5'd9;
    s.wd0 = 32'h11; s.wd1 = 32'h22; cycle(s);
    s = idle(); s.r1 = 5'd9; s.dbg = 5'd9; cycle(s);
    s = idle(); s.r2 = 5'd9; cycle(s);
    s = idle(); s.we0 = 1'b1; s.we1 = 1'b1; s.rw0 = 5'd0; s.rw1 = 5'd0;
    s.wd0 = 32'h11; s.wd1 = 32'h22; cycle(s);
    s = idle(); s.r1 = 5'd0; s.dbg = 5'd0; cycle(s);
    s = idle(); cycle(s);

    // Bypass versus debug read of entry 3.
    s = idle(); s.we0 = 1'b1; s.rw0 = 5'd3; s.wd0 = 32'h5; cycle(s);
    s = idle(); s.we0 = 1'b1; s.rw0 = 5'd3; s.wd0 = 32'hA; s.r2 = 5'd3; s.dbg = 5'd3; cycle(s);
    s = idle(); s.r2 = 5'd3; s.dbg = 5'd3; cycle(s);

    // Reset again, then interrupt the sweep at cycle 10.
    s = idle(); s.rst = 1'b1; cycle(s);
    for (int i = 0; i < 10; i++) begin
      s = idle(); s.we1 = 1'b1; s.rw1 = 5'(i); s.wd1 = 32'h1234_5678; cycle(s);
    end
    s = idle(); s.rst = 1'b1; cycle(s);
    for (int i = 0; i < 34; i++) begin
      s = idle(); s.dbg = 5'(i); s.r1 = 5'(i); cycle(s);
    end

    // Write to entry 0: kept by the no-zero build, dropped by the default.
    s = idle(); s.we0 = 1'b1; s.rw0 = 5'd0; s.wd0 = 32'h0000_BEEF; cycle(s);
    s = idle(); s.r1 = 5'd0; s.dbg = 5'd0; cycle(s);

    for (int i = 0; i < 500; i++) cycle(rnd_stim());
    s = idle();
    cycle(s);

    repeat (2) @(posedge clk);
    check("drain_a", 32'(q_a.size()), 32'h0);
    check("drain_b", 32'(q_b.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
